// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int unsigned DEPTH_DEFAULT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// Framed word-stream loader: header count, payload to imem, XOR checksum.
// Holds the core in reset until a verified image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int IW = $clog2(DEPTH);
    localparam int RW = IW + 1;

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic [RW-1:0]   rem_q;
    logic [31:0]     csum_q;
    logic            we_q;
    logic [31:0]     waddr_q;
    logic [31:0]     wdata_q;
    logic            xfer;
    logic            hdr_bad;

    assign xfer    = in_valid & in_ready;
    assign hdr_bad = (in_data == 32'd0) || (in_data > 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) state_q <= HEADER;
                end
                HEADER: begin
                    if (xfer) begin
                        if (hdr_bad) begin
                            state_q <= ERROR;
                        end else begin
                            rem_q   <= in_data[RW-1:0];
                            idx_q   <= '0;
                            csum_q  <= '0;
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        we_q    <= 1'b1;
                        waddr_q <= {{(30-IW){1'b0}}, idx_q, 2'b00};
                        wdata_q <= in_data;
                        csum_q  <= csum_q ^ in_data;
                        idx_q   <= idx_q + 1'b1;
                        rem_q   <= rem_q - 1'b1;
                        if (rem_q == RW'(1)) state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        state_q <= (in_data == csum_q) ? DONE : ERROR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Status is a pure decode of the state register: no input-to-output path.
    assign busy       = (state_q == HEADER) || (state_q == DATA) ||
                        (state_q == CHECK);
    assign in_ready   = busy;
    assign cpu_hold   = busy || (state_q == ERROR);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at each payload
// transfer, popped and compared whenever imem_we is seen.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad = 0;
    int nwr = 0;
    logic [31:0] exp_addr;
    logic [63:0] sb[$];

    imem_loader #(.DEPTH(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            nwr++;
            if (sb.size() == 0) begin
                chk("spurious_we", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("waddr", imem_waddr, e[63:32]);
                chk("wdata", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input bit pay);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (pay) begin
            sb.push_back({exp_addr, d});
            exp_addr = exp_addr + 32'd4;
        end
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] words[$], input logic [31:0] cs);
        pulse_start();
        exp_addr = 32'd0;
        send(32'(words.size()), 1'b0);
        foreach (words[i]) send(words[i], 1'b1);
        send(cs, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] w[$];
        logic [31:0] cs;
        int base;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        exp_addr = '0;
        tick(2);
        reset = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_waddr", imem_waddr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);

        // Valid data with no start must be ignored.
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        tick(4);
        chk("idle_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Nominal load.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("start_ready", 32'(in_ready), 32'd1);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        exp_addr = 32'd0;
        send(32'd3, 1'b0);
        send(32'h00500113, 1'b1);
        send(32'h00C00193, 1'b1);
        send(32'hFF718393, 1'b1);
        send(32'h00500113 ^ 32'h00C00193 ^ 32'hFF718393, 1'b0);
        chk("nom_done", 32'(done), 32'd1);
        chk("nom_hold", 32'(cpu_hold), 32'd0);
        chk("nom_error", 32'(error), 32'd0);
        chk("nom_busy", 32'(busy), 32'd0);
        chk("nom_nwr", 32'(nwr), 32'd3);

        // Bad headers.
        base = nwr;
        pulse_start();
        chk("restart_done_clr", 32'(done), 32'd0);
        send(32'd0, 1'b0);
        chk("hdr0_error", 32'(error), 32'd1);
        chk("hdr0_hold", 32'(cpu_hold), 32'd1);
        pulse_start();
        chk("retry_err_clr", 32'(error), 32'd0);
        send(32'd1025, 1'b0);
        chk("hdr1025_error", 32'(error), 32'd1);
        pulse_start();
        send(32'hFFFFFFFF, 1'b0);
        chk("hdrmax_error", 32'(error), 32'd1);
        tick(2);
        chk("hdr_nwr", 32'(nwr - base), 32'd0);

        // Bad checksum, then a good retry.
        w = '{32'h1, 32'h2};
        load(w, 32'h0);
        chk("cs_error", 32'(error), 32'd1);
        chk("cs_done", 32'(done), 32'd0);
        tick(3);
        chk("cs_hold", 32'(cpu_hold), 32'd1);
        load(w, 32'h3);
        chk("retry_done", 32'(done), 32'd1);
        chk("retry_error", 32'(error), 32'd0);

        // Bubbles in in_valid plus ignored start pulses during DATA.
        base = nwr;
        pulse_start();
        exp_addr = 32'd0;
        send(32'd5, 1'b0);
        cs = '0;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] d;
            int gap;
            d = $urandom;
            cs ^= d;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                start = (g == 0);
                in_valid = 1'b0;
                tick(1);
            end
            start = 1'b0;
            send(d, 1'b1);
        end
        chk("gap_busy", 32'(busy), 32'd1);
        send(cs, 1'b0);
        chk("gap_done", 32'(done), 32'd1);
        tick(1);
        chk("gap_nwr", 32'(nwr - base), 32'd5);

        // Reset in the cycle after the 2nd of 4 payload transfers.
        base = nwr;
        pulse_start();
        exp_addr = 32'd0;
        send(32'd4, 1'b0);
        send(32'hAAAA0001, 1'b1);
        send(32'hAAAA0002, 1'b1);
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hAAAA0003;
        tick(1);
        chk("mid_hold", 32'(cpu_hold), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_we", 32'(imem_we), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_error", 32'(error), 32'd0);
        reset = 1'b0;
        tick(3);
        in_valid = 1'b0;
        chk("mid_nwr", 32'(nwr - base), 32'd2);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader and write-port sequencer for the single-cycle core's instruction memory. Accepts a framed word stream from a host link (header = word count, payload, XOR checksum) and writes the payload to consecutive word addresses of the instruction RAM write port. Holds the core in reset during the load and releases it only after a verified image. Sits between the host interface (UART word assembler or testbench) and the instruction memory, alongside the core's read-only fetch port.

## Interface
- DEPTH, 1024, instruction RAM size in words; maximum legal header count
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load; ignored unless state is IDLE, DONE or ERROR
- in_valid  input  1  host word valid
- in_data  input  32  host word
- in_ready  output  1  loader accepts in_data this cycle; a transfer occurs when in_valid & in_ready
- imem_we  output  1  instruction RAM write enable, registered
- imem_waddr  output  32  byte address, always word-aligned (bits [1:0] = 0), registered
- imem_wdata  output  32  write data, registered
- cpu_hold  output  1  holds core in reset while 1
- busy  output  1  state is HEADER, DATA or CHECK
- done  output  1  last load verified
- error  output  1  last load rejected

## Operation
- States: IDLE, HEADER, DATA, CHECK, DONE, ERROR.
- IDLE: in_ready=0, cpu_hold=0. The core runs any image already present. start -> HEADER.
- HEADER: in_ready=1, cpu_hold=1. On transfer, N=in_data.
  - N==0 or N>DEPTH -> ERROR.
  - Otherwise remaining=N, word index=0, csum=0 -> DATA.
- DATA: in_ready=1, cpu_hold=1. Each transfer:
  - registers imem_we=1, imem_waddr={index,2'b00}, imem_wdata=in_data
  - csum ^= in_data; index++, remaining--
  - On the transfer that makes remaining 0 -> CHECK.
- CHECK: in_ready=1, cpu_hold=1. On transfer, in_data==csum -> DONE, else -> ERROR. Written words are not rolled back.
- DONE: done=1, cpu_hold=0, in_ready=0. start -> HEADER, which clears done.
- ERROR: error=1, cpu_hold=1, in_ready=0. The core stays held until start (retry) or reset. start clears error.
- start in HEADER/DATA/CHECK: ignored.
- in_valid while in_ready=0: word is not consumed, with no side effects.

## Timing
- Reset values:
  - state=IDLE; index, remaining and csum = 0.
  - All outputs 0: in_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, error.
- Reset during a load: IDLE on the next edge and cpu_hold drops. Any write registered in that cycle is suppressed (imem_we=0). The partial image is left in RAM.
- start -> in_ready=1 on the following cycle (one-cycle latency).
- A data transfer in cycle t -> imem_we pulses high for exactly one cycle, t+1. Addr and data are valid in the same cycle.
- Full throughput: one word per cycle with in_valid held high. Gaps in in_valid produce no writes.
- Index width is clog2(DEPTH). No wrap is possible, because N<=DEPTH is checked in HEADER.
- After the last payload word, the checksum can be accepted the next cycle.
- done/error assert the cycle after the checksum transfer. cpu_hold falls in the same cycle as done rises.
- Header check: N is compared as an unsigned 32-bit value, so 0xFFFFFFFF -> ERROR.
- in_ready, busy, done, error and cpu_hold are decoded from the state register only. No combinational path from input to output.

## Structure
- Package imem_loader_pkg: state enum (IDLE, HEADER, DATA, CHECK, DONE, ERROR) and default DEPTH constant.
- Single module; no sub-module needed. The checksum is an inline XOR accumulator.
- The instruction memory gains a synchronous write port (we/waddr/wdata on clk), used only by this block. The fetch read port is unchanged.

## Test plan
- Reset: assert reset for 2 cycles -> all outputs 0, state IDLE. in_valid=1 with no start -> no writes.
- Nominal load: start; then the stream 3, 0x00500113, 0x00C00193, 0xFF718393, and checksum = XOR of the three words.
  - Writes at addrs 0x0, 0x4, 0x8 with matching data, one cycle after each transfer.
  - done=1 and cpu_hold=0 one cycle after the checksum transfer.
- Bad headers: header 0 -> error=1, no imem_we. Header 1025 (DEPTH=1024) -> error=1, no imem_we.
- Bad checksum: header 2, words 0x1 and 0x2, checksum 0x0 -> error=1 and cpu_hold stays 1.
  - Then start plus a correct stream -> done=1 and error=0.
- Backpressure/gaps: random in_valid bubbles during DATA -> exactly N writes, addresses contiguous.
  - start pulses during DATA are ignored.
- Reset mid-load: reset asserted in the cycle after the 2nd of 4 payload transfers -> IDLE, cpu_hold=0 next edge; no 3rd write; done=error=0.
